// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned DIV_N_DEF = 4;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_w(DIV_N_DEF);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N_DEF
) (
  input  logic [N-1:0] partial_rem,
  input  logic         dvd_bit,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] new_rem,
  output logic         q_bit
);

  logic [N:0] shifted;
  logic [N:0] trial;

  // partial_rem < divisor holds on entry, so bit N of the trial is a valid sign.
  always_comb begin
    shifted = {partial_rem, dvd_bit};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[N];
    new_rem = q_bit ? trial[N-1:0] : shifted[N-1:0];
  end

endmodule

// File: rtl/div4_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional macro DIV4_DBZ_FLAG_EN adds a dbz output and a fast divide-by-zero path.
module div4_seq
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
`ifdef DIV4_DBZ_FLAG_EN
  output logic         dbz,
`endif
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  localparam int unsigned CW = cnt_w(N);

  state_e        state_q;
  logic [N-1:0]  dvd_q;
  logic [N-1:0]  dvs_q;
  logic [N-1:0]  prem_q;
  logic [N-2:0]  qw_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  quot_q;
  logic [N-1:0]  rem_q;
`ifdef DIV4_DBZ_FLAG_EN
  logic          dbz_q;
`endif

  logic [N-1:0]  rem_d;
  logic          qbit_d;
  logic [N-1:0]  quot_d;

  div_step #(.N(N)) u_step (
    .partial_rem (prem_q),
    .dvd_bit     (dvd_q[N-1]),
    .divisor     (dvs_q),
    .new_rem     (rem_d),
    .q_bit       (qbit_d)
  );

  assign quot_d = {qw_q, qbit_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      qw_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIV4_DBZ_FLAG_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            prem_q <= '0;
            qw_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            state_q <= RUN;
`ifdef DIV4_DBZ_FLAG_EN
            if (divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
              quot_q  <= '1;
              rem_q   <= dividend;
            end
`endif
          end
        end
        RUN: begin
          prem_q <= rem_d;
          dvd_q  <= {dvd_q[N-2:0], 1'b0};
          qw_q   <= quot_d[N-2:0];
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
`ifdef DIV4_DBZ_FLAG_EN
          dbz_q   <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
`ifdef DIV4_DBZ_FLAG_EN
  assign dbz       = dbz_q;
`endif

endmodule

// File: tb/tb_div4_seq.sv
// Self-checking bench for div4_seq: directed timing scenarios plus randomized operands.
module tb_div4_seq;

  localparam int unsigned N = 4;
`ifdef DIV4_DBZ_FLAG_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
`ifdef DIV4_DBZ_FLAG_EN
  logic         dbz;
`endif

  int checks   = 0;
  int failures = 0;

  div4_seq #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
`ifdef DIV4_DBZ_FLAG_EN
    .dbz       (dbz),
`endif
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
    return (b == 0) ? {N{1'b1}} : N'(a / b);
  endfunction

  function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b);
    return (b == 0) ? a : N'(a % b);
  endfunction

  // Start one division in the current cycle and follow it to completion.
  task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b, input bit noisy);
    int cyc;
    int lat;
    lat = (DBZ_EN && b == 0) ? 1 : N + 1;
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      check("busy_run", busy, 1);
      if (noisy) begin
        start    = 1'($urandom);
        dividend = N'($urandom);
        divisor  = N'($urandom);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("latency", cyc, lat);
    check("busy_done", busy, 1);
    check("quotient", quotient, ref_q(a, b));
    check("remainder", remainder, ref_r(a, b));
`ifdef DIV4_DBZ_FLAG_EN
    check("dbz", dbz, (b == 0));
`endif
    tick();
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    tick();
    check("quot_hold", quotient, ref_q(a, b));
    check("rem_hold", remainder, ref_r(a, b));
  endtask

  initial begin
    int ndone;
    logic [N-1:0] a, b;

    reset = 1'b1; start = 1'b1; dividend = 4'd5; divisor = 4'd1;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    reset = 1'b0; start = 1'b0;

    do_div(4'd13, 4'd3, 1'b0);
    do_div(4'd15, 4'd1, 1'b0);
    do_div(4'd2, 4'd7, 1'b0);
    do_div(4'd9, 4'd0, 1'b0);

    // Second start while busy must be ignored.
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; dividend = 4'd6; divisor = 4'd2;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int c = 3; c < 14; c++) begin
      if (done) begin
        ndone++;
        check("ign_cycle", c, 5);
        check("ign_quot", quotient, 2);
        check("ign_rem", remainder, 2);
      end
      tick();
    end
    check("ign_ndone", ndone, 1);

    // Reset mid-operation discards everything.
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_quot", quotient, 0);
    check("mid_rst_rem", remainder, 0);
    do_div(4'd14, 4'd3, 1'b0);

    // Start held high: second operation only after returning to IDLE.
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    tick();
    dividend = 4'd8; divisor = 4'd3;
    ndone = 0;
    for (int c = 1; c < 16; c++) begin
      if (c == 12) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("b2b_cyc1", c, 5);
          check("b2b_q1", quotient, 3);
          check("b2b_r1", remainder, 1);
        end else if (ndone == 2) begin
          check("b2b_cyc2", c, 11);
          check("b2b_q2", quotient, 2);
          check("b2b_r2", remainder, 2);
        end
      end
      tick();
    end
    check("b2b_ndone", ndone, 2);
    start = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      do_div(a, b, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
